// File: rtl/clk_phase_pkg.sv
// Shared types and reset defaults for the phase-programmable clock/strobe generator.
// Holds the per-channel {rise, fall} record, the period register address and the
// reset-time window table used by every channel instance.
package clk_phase_pkg;

    localparam int PKG_CNT_W = 8;

    // Address that selects the period register instead of a channel.
    localparam logic [3:0] CFG_ADDR_PERIOD = 4'd0;

    typedef struct packed {
        logic [PKG_CNT_W-1:0] rise;
        logic [PKG_CNT_W-1:0] fall;
    } ch_cfg_t;

    // Reset windows. A fall of 100 sits at or beyond the default period, so those
    // channels stay high until the period ends. Channels 4..7 come up disabled.
    function automatic ch_cfg_t def_cfg(input int ch);
        ch_cfg_t c;
        case (ch)
            0:       c = '{rise: 8'd6,  fall: 8'd70};
            1:       c = '{rise: 8'd0,  fall: 8'd50};
            2:       c = '{rise: 8'd80, fall: 8'd100};
            3:       c = '{rise: 8'd90, fall: 8'd100};
            default: c = '{rise: 8'd0,  fall: 8'd0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/clk_phase_chan.sv
// One output channel: shadow/active window registers, window compare, output regs.
// Latency: clk_out and rise_pulse are registered, one cycle behind the shared counter.
// Backpressure: none; run = 0 holds clk_out and zeroes rise_pulse, restart clears both.
// Ports: clk_100M/rst_n clock and async reset; run/restart/apply control from the top;
//        wr_en/wr_rise/wr_fall shadow write; cnt shared counter; clk_out/rise_pulse outputs.
module clk_phase_chan
    import clk_phase_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int CH    = 0
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic             apply,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_rise,
    input  logic [CNT_W-1:0] wr_fall,
    input  logic [CNT_W-1:0] cnt,
    output logic             clk_out,
    output logic             rise_pulse
);

    localparam ch_cfg_t          DEF      = def_cfg(CH);
    localparam logic [CNT_W-1:0] DEF_RISE = CNT_W'(DEF.rise);
    localparam logic [CNT_W-1:0] DEF_FALL = CNT_W'(DEF.fall);

    logic [CNT_W-1:0] act_rise, act_fall;
    logic [CNT_W-1:0] shd_rise, shd_fall;
    logic             win;

    // cnt never reaches the period, so a rise at or past the period never hits and
    // a fall at or past it never ends the window early: truncation comes for free.
    always_comb begin
        win = 1'b0;
        if (act_rise < act_fall) begin
            win = (cnt >= act_rise) && (cnt < act_fall);
        end else if (act_rise > act_fall) begin
            win = (cnt >= act_rise) || (cnt < act_fall);
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            act_rise   <= DEF_RISE;
            act_fall   <= DEF_FALL;
            shd_rise   <= DEF_RISE;
            shd_fall   <= DEF_FALL;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            if (wr_en) begin
                shd_rise <= wr_rise;
                shd_fall <= wr_fall;
            end
            // Active takes the shadow as it stood before this edge, so a write on
            // the apply edge waits for the next boundary.
            if (apply) begin
                act_rise <= shd_rise;
                act_fall <= shd_fall;
            end
            if (restart) begin
                clk_out    <= 1'b0;
                rise_pulse <= 1'b0;
            end else if (run) begin
                clk_out    <= win;
                rise_pulse <= win & ~clk_out;
            end else begin
                rise_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel phase-programmable clock/strobe generator with glitch-free reconfig.
// Latency: outputs lag the shared period counter by one cycle; cfg_err one cycle after the write.
// Backpressure: none; run = 0 freezes counter and outputs, restart zeroes and applies shadow.
// Ports: clk_100M/rst_n clock and async reset; run/restart control; cfg_we/cfg_addr/
//        cfg_rise/cfg_fall config write; clk_out/rise_pulse per channel; wrap,
//        cfg_pending, cfg_err status.
module clk_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 100
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              run,
    input  logic              restart,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_rise,
    input  logic [CNT_W-1:0]  cfg_fall,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic              wrap,
    output logic              cfg_pending,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_PER   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_PER   = CNT_W'(DEF_PERIOD);
    localparam logic [3:0]       MAX_ADDR  = 4'(NUM_CH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] shd_period;
    logic             at_end;
    logic             apply;
    logic             period_sel;
    logic             cfg_ok;
    logic             wr_ok;

    assign at_end     = (cnt == period - ONE);
    assign apply      = restart | (run & at_end);
    assign period_sel = (cfg_addr == CFG_ADDR_PERIOD);
    // A period below 2 could never toggle a window, so it is refused like a bad address.
    assign cfg_ok     = (cfg_addr <= MAX_ADDR) && !(period_sel && (cfg_rise < MIN_PER));
    assign wr_ok      = cfg_we & cfg_ok;

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period      <= DEF_PER;
            shd_period  <= DEF_PER;
            wrap        <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (restart) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= at_end ? '0 : cnt + ONE;
            end

            wrap    <= ~restart & run & at_end;
            cfg_err <= cfg_we & ~cfg_ok;

            if (wr_ok && period_sel) begin
                shd_period <= cfg_rise;
            end
            if (apply) begin
                period <= shd_period;
            end

            // A fresh write outranks the clear so a write on the apply edge stays pending.
            if (wr_ok) begin
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        logic chan_we;
        assign chan_we = wr_ok && (cfg_addr == 4'(ch + 1));

        clk_phase_chan #(
            .CNT_W (CNT_W),
            .CH    (ch)
        ) u_chan (
            .clk_100M   (clk_100M),
            .rst_n      (rst_n),
            .run        (run),
            .restart    (restart),
            .apply      (apply),
            .wr_en      (chan_we),
            .wr_rise    (cfg_rise),
            .wr_fall    (cfg_fall),
            .cnt        (cnt),
            .clk_out    (clk_out[ch]),
            .rise_pulse (rise_pulse[ch])
        );
    end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: a table of {inputs, cycles, expected outputs}
// applied in order, followed by hand-written reset-mid-period and wrap-spacing sequences.
module tb_clk_phase_gen;

    logic       clk_100M;
    logic       rst_n;
    logic       run;
    logic       restart;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_rise;
    logic [7:0] cfg_fall;
    logic [3:0] clk_out;
    logic [3:0] rise_pulse;
    logic       wrap;
    logic       cfg_pending;
    logic       cfg_err;

    int total;
    int bad;

    clk_phase_gen #(
        .NUM_CH     (4),
        .CNT_W      (8),
        .DEF_PERIOD (100)
    ) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .run         (run),
        .restart     (restart),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_rise    (cfg_rise),
        .cfg_fall    (cfg_fall),
        .clk_out     (clk_out),
        .rise_pulse  (rise_pulse),
        .wrap        (wrap),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic       run;
        logic       rst;
        logic       we;
        logic [3:0] addr;
        logic [7:0] rise;
        logic [7:0] fall;
        int         n;
        logic       each;
        logic [3:0] e_clk;
        logic [3:0] e_rp;
        logic       e_wrap;
        logic       e_pend;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    task automatic add(input logic r, input logic rs, input logic we, input logic [3:0] a,
                       input logic [7:0] ri, input logic [7:0] fa, input int n, input logic each,
                       input logic [3:0] ec, input logic [3:0] erp, input logic ew,
                       input logic ep, input logic ee);
        vec_t t;
        t = '{run: r, rst: rs, we: we, addr: a, rise: ri, fall: fa, n: n, each: each,
              e_clk: ec, e_rp: erp, e_wrap: ew, e_pend: ep, e_err: ee};
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0h want=%0h t=%0t", name, idx, got, want, $time);
        end
    endtask

    task automatic chk_vec(input int i, input vec_t x);
        check("clk_out",     i, 32'(clk_out),     32'(x.e_clk));
        check("rise_pulse",  i, 32'(rise_pulse),  32'(x.e_rp));
        check("wrap",        i, 32'(wrap),        32'(x.e_wrap));
        check("cfg_pending", i, 32'(cfg_pending), 32'(x.e_pend));
        check("cfg_err",     i, 32'(cfg_err),     32'(x.e_err));
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    int cyc;
    logic found;

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        restart  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_rise = '0;
        cfg_fall = '0;

        // Defaults: ch0 6..69, ch1 0..49, ch2 80..99, ch3 90..99, period 100.
        //   run rs we addr rise fall   n each  clk      rp       wr pe er
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0010, 4'b0010, 0, 0, 0); // c=0
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  6, 0, 4'b0011, 4'b0001, 0, 0, 0); // c=6 ch0 rises (7th edge)
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0011, 4'b0000, 0, 0, 0); // c=7
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 32, 0, 4'b0011, 4'b0000, 0, 0, 0); // c=39, cnt now 40
        add(0, 0, 0, 4'd0, 8'd0,  8'd0, 37, 1, 4'b0011, 4'b0000, 0, 0, 0); // stall, checked each cycle
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 10, 0, 4'b0011, 4'b0000, 0, 0, 0); // c=49
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0001, 4'b0000, 0, 0, 0); // c=50 ch1 falls
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 20, 0, 4'b0000, 4'b0000, 0, 0, 0); // c=70 ch0 falls
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  9, 0, 4'b0000, 4'b0000, 0, 0, 0); // c=79
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0100, 0, 0, 0); // c=80
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  9, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=89
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b1100, 4'b1000, 0, 0, 0); // c=90
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  8, 0, 4'b1100, 4'b0000, 0, 0, 0); // c=98, no early wrap
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b1100, 4'b0000, 1, 0, 0); // c=99 wrap, 37 late
        // Mid-period reconfig: period 10, ch1 2/5, ch2 8/2, ch3 4/4.
        add(1, 0, 1, 4'd0, 8'd10, 8'd0,  1, 0, 4'b0010, 4'b0010, 0, 1, 0); // c=0
        add(1, 0, 1, 4'd2, 8'd2,  8'd5,  1, 0, 4'b0010, 4'b0000, 0, 1, 0); // c=1
        add(1, 0, 1, 4'd3, 8'd8,  8'd2,  1, 0, 4'b0010, 4'b0000, 0, 1, 0); // c=2
        add(1, 0, 1, 4'd4, 8'd4,  8'd4,  1, 0, 4'b0010, 4'b0000, 0, 1, 0); // c=3
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 95, 0, 4'b1100, 4'b0000, 0, 1, 0); // c=98 still pending
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b1100, 4'b0000, 1, 0, 0); // c=99 apply
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=0 ch2 wrapped window
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=1
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0010, 4'b0010, 0, 0, 0); // c=2
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  2, 0, 4'b0010, 4'b0000, 0, 0, 0); // c=4
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0000, 4'b0000, 0, 0, 0); // c=5
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0001, 4'b0001, 0, 0, 0); // c=6 ch0 fall 70 truncated
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0001, 4'b0000, 0, 0, 0); // c=7
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0101, 4'b0100, 0, 0, 0); // c=8
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0101, 4'b0000, 1, 0, 0); // c=9 wrap
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=0
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 10, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=0 one period later
        // Rejected writes.
        add(1, 0, 1, 4'd0, 8'd1,  8'd0,  1, 0, 4'b0100, 4'b0000, 0, 0, 1); // c=1 period=1
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0010, 4'b0010, 0, 0, 0); // c=2
        add(1, 0, 1, 4'd7, 8'd3,  8'd4,  1, 0, 4'b0010, 4'b0000, 0, 0, 1); // c=3 addr 7
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0010, 4'b0000, 0, 0, 0); // c=4
        add(1, 0, 1, 4'd5, 8'd3,  8'd4,  1, 0, 4'b0000, 4'b0000, 0, 0, 1); // c=5 addr NUM_CH+1
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0001, 4'b0001, 0, 0, 0); // c=6
        // Back to period 100, ch1 50/60.
        add(1, 0, 1, 4'd0, 8'd100, 8'd0, 1, 0, 4'b0001, 4'b0000, 0, 1, 0); // c=7
        add(1, 0, 1, 4'd2, 8'd50, 8'd60, 1, 0, 4'b0101, 4'b0100, 0, 1, 0); // c=8
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0101, 4'b0000, 1, 0, 0); // c=9 apply
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 55, 0, 4'b0111, 4'b0000, 0, 0, 0); // c=54, cnt now 55
        // Restart while stalled applies the shadow.
        add(0, 0, 1, 4'd1, 8'd1,  8'd3,  1, 0, 4'b0111, 4'b0000, 0, 1, 0); // frozen, shadow ch0 1/3
        add(0, 1, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0000, 4'b0000, 0, 0, 0); // restart
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0100, 0, 0, 0); // c=0
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0101, 4'b0001, 0, 0, 0); // c=1 new ch0
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0001, 4'b0000, 0, 0, 0); // c=2
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0000, 4'b0000, 0, 0, 0); // c=3
        add(1, 0, 0, 4'd0, 8'd0,  8'd0, 95, 0, 4'b0100, 4'b0000, 0, 0, 0); // c=98
        // Write on the wrap edge stays pending.
        add(1, 0, 1, 4'd2, 8'd0,  8'd1,  1, 0, 4'b0100, 4'b0000, 1, 1, 0); // c=99
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0100, 4'b0000, 0, 1, 0); // c=0 ch1 unchanged
        add(1, 1, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0000, 4'b0000, 0, 0, 0); // restart applies it
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0110, 4'b0110, 0, 0, 0); // c=0
        add(1, 0, 0, 4'd0, 8'd0,  8'd0,  1, 0, 4'b0101, 4'b0001, 0, 0, 0); // c=1

        // Reset state, sampled while reset is held and between clock edges.
        #12;
        check("rst_clk_out", 0, 32'(clk_out),     32'h0);
        check("rst_rp",      0, 32'(rise_pulse),  32'h0);
        check("rst_wrap",    0, 32'(wrap),        32'h0);
        check("rst_pending", 0, 32'(cfg_pending), 32'h0);
        check("rst_err",     0, 32'(cfg_err),     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v        = tbl[i];
            run      = v.run;
            restart  = v.rst;
            cfg_we   = v.we;
            cfg_addr = v.addr;
            cfg_rise = v.rise;
            cfg_fall = v.fall;
            tick();
            restart = 1'b0;
            cfg_we  = 1'b0;
            if (v.each) chk_vec(i, v);
            for (int k = 1; k < v.n; k++) begin
                tick();
                if (v.each) chk_vec(i, v);
            end
            if (!v.each) chk_vec(i, v);
        end

        // Reset mid-period with a pending write: shadow must be discarded.
        run      = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd1;
        cfg_rise = 8'd20;
        cfg_fall = 8'd30;
        tick();
        cfg_we = 1'b0;
        check("pre_rst_pending", 1, 32'(cfg_pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_clk_out", 1, 32'(clk_out),     32'h0);
        check("mid_rst_pending", 1, 32'(cfg_pending), 32'h0);
        #2;
        rst_n = 1'b1;
        repeat (7) tick();
        check("post_rst_clk_out", 1, 32'(clk_out),     32'h3);
        check("post_rst_rp",      1, 32'(rise_pulse),  32'h1);
        check("post_rst_pending", 1, 32'(cfg_pending), 32'h0);

        // Wrap spacing after reset: first at edge 100, then every 100 edges.
        cyc   = 7;
        found = 1'b0;
        while (!found && cyc < 300) begin
            tick();
            cyc++;
            if (wrap) found = 1'b1;
        end
        check("first_wrap_edge", 2, 32'(cyc), 32'd100);
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 300) begin
            tick();
            cyc++;
            if (wrap) found = 1'b1;
        end
        check("wrap_spacing", 2, 32'(cyc), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
